// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 max-pooling controller.
package pool_pkg;

    typedef enum logic {
        FILL = 1'b0,
        POOL = 1'b1
    } state_t;

    // Counter width for a 0..n-1 count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2x2_ctrl_max4.sv
// Four-input signed maximum, purely combinational, no width growth.
// Ties resolve to the earlier operand (a > b > c > d).
module maxpool2x2_ctrl_max4 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    output logic signed [DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] ab;
    logic signed [DATA_WIDTH-1:0] cd;

    always_comb begin
        ab = (b > a) ? b : a;
        cd = (d > c) ? d : c;
        y  = (cd > ab) ? cd : ab;
    end

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// Streaming 2x2/stride-2 signed max-pool: buffers even rows, pools on odd rows.
// Latency: result registered on the edge accepting the window's last pixel.
// Backpressure: in_ready drops whenever a result is pending and out_ready is low.
module maxpool2x2_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    generate
        if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
            $error("maxpool2x2_ctrl: IMG_W and IMG_H must be even and >= 2");
        end
    endgenerate

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] line_buf [IMG_W];
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] max_y;
    logic [CW-1:0]         col_even;
    logic                  beat;
    logic                  col_last;
    logic                  row_last;
    logic                  load;
    logic                  out_last;

    assign in_ready = !out_valid || out_ready;
    assign beat     = in_valid && in_ready;
    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);
    assign load     = beat && (state == POOL) && col[0];
    assign col_even = col & ~CW'(1);

    always_comb begin
        state_nxt = state;
        if (beat && col_last) begin
            state_nxt = (state == FILL) ? POOL : FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_nxt;
            if (beat) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Storage is always written before it is read, so it carries no reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            if (state == FILL) begin
                line_buf[col] <= in_data;
            end else if (!col[0]) begin
                hold_reg <= in_data;
            end
        end
    end

    maxpool2x2_ctrl_max4 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_max4 (
        .a (line_buf[col_even]),
        .b (line_buf[col]),
        .c (hold_reg),
        .d (in_data),
        .y (max_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= max_y;
                out_last  <= row_last && col_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A new frame starting in the frame_done cycle keeps busy high.
            if (beat && row == '0 && col == '0) begin
                busy <= 1'b1;
            end else if (frame_done) begin
                busy <= 1'b0;
            end
        end
    end

    // Registered last-pixel tag qualified by the live handshake, so the pulse
    // lands exactly on the cycle the final result is taken, even after a stall.
    assign frame_done = out_valid && out_ready && out_last;

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Directed bench for maxpool2x2_ctrl: a 4x2 instance and a 4x4 instance share stimulus.
module tb_maxpool2x2_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, fd_a, busy_a;
    logic [15:0] out_data_a;
    logic        in_ready_b, out_valid_b, fd_b, busy_b;
    logic [15:0] out_data_b;

    int total = 0;
    int bad   = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;

    always #5 clk = ~clk;

    maxpool2x2_ctrl #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .frame_done(fd_a), .busy(busy_a)
    );

    maxpool2x2_ctrl #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .frame_done(fd_b), .busy(busy_b)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_a && out_ready) qa.push_back(out_data_a);
            if (out_valid_b && out_ready) qb.push_back(out_data_b);
            if (fd_a) fd_cnt_a++;
            if (fd_b) fd_cnt_b++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_pixel(input logic [15:0] d, input bit use_b);
        int n = 0;
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = use_b ? in_ready_b : in_ready_a;
            n++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            total++; bad++;
            $display("FAIL send_timeout got=in_ready low for %0d cycles want=accept", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        qa.delete(); qb.delete();
        fd_cnt_a = 0; fd_cnt_b = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid_a); end
        total++; if (out_data_a !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h want=0000", out_data_a); end
        total++; if (fd_a !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", fd_a); end
        total++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b want=00", busy_a, busy_b); end
        total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready_a); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int px[8] = '{1, 5, -3, 2, 4, 0, -7, -1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_pixel(16'(px[i]), 1'b0);
            if (i == 4) begin
                total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL basic_fill_quiet got=valid%b busy%b want=valid0 busy1", out_valid_a, busy_a); end
            end
            if (i == 5) begin
                total++; if (out_valid_a !== 1'b1 || out_data_a !== 16'd5 || fd_a !== 1'b0) begin bad++; $display("FAIL basic_first got=v%b d%0d fd%b want=v1 d5 fd0", out_valid_a, $signed(out_data_a), fd_a); end
            end
            if (i == 7) begin
                total++; if (out_valid_a !== 1'b1 || out_data_a !== 16'd2 || fd_a !== 1'b1 || busy_a !== 1'b1) begin bad++; $display("FAIL basic_last got=v%b d%0d fd%b busy%b want=v1 d2 fd1 busy1", out_valid_a, $signed(out_data_a), fd_a, busy_a); end
            end
        end
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0 || fd_a !== 1'b0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL basic_idle got=busy%b fd%b v%b want=000", busy_a, fd_a, out_valid_a); end
        total++; if (fd_cnt_a != 1 || qa.size() != 2) begin bad++; $display("FAIL basic_counts got=fd%0d outs%0d want=fd1 outs2", fd_cnt_a, qa.size()); end
    endtask

    task automatic test_signed();
        int px[8] = '{-8, -3, 32767, -32768, -5, -32768, -32768, -32768};
        logic [15:0] e0, e1;
        e0 = 16'hFFFD;
        e1 = 16'h7FFF;
        do_reset();
        for (int i = 0; i < 8; i++) send_pixel(16'(px[i]), 1'b0);
        @(posedge clk); #1;
        total++;
        if (qa.size() != 2) begin
            bad++; $display("FAIL signed_count got=%0d want=2", qa.size());
        end else if (qa[0] !== e0 || qa[1] !== e1) begin
            bad++; $display("FAIL signed_values got=%h,%h want=%h,%h", qa[0], qa[1], e0, e1);
        end
    endtask

    task automatic test_backpressure();
        int px[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
        do_reset();
        for (int i = 0; i < 6; i++) send_pixel(16'(px[i]), 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'd70;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if ({in_ready_a, out_valid_a, out_data_a} !== {1'b0, 1'b1, 16'd60}) begin bad++; $display("FAIL bp_stall got=rdy%b v%b d%0d want=rdy0 v1 d60", in_ready_a, out_valid_a, out_data_a); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_pixel(16'd70, 1'b0);
        send_pixel(16'd80, 1'b0);
        @(posedge clk); #1;
        total++;
        if (qa.size() != 2) begin
            bad++; $display("FAIL bp_count got=%0d want=2", qa.size());
        end else if (qa[0] !== 16'd60 || qa[1] !== 16'd80) begin
            bad++; $display("FAIL bp_order got=%0d,%0d want=60,80", qa[0], qa[1]);
        end
        total++; if (fd_cnt_a != 1) begin bad++; $display("FAIL bp_frame_done got=%0d want=1", fd_cnt_a); end
    endtask

    task automatic test_gaps_4x4();
        int px[16] = '{3, -2, 7, 100, -9, 12, 6, -100, -1, -1, -50, -60, -1, -4, -70, -55};
        int ex[4]  = '{12, 100, -1, -50};
        bit busy_ok = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_pixel(16'(px[i]), 1'b1);
            busy_ok &= (busy_b === 1'b1);
            if (i < 15) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    busy_ok &= (busy_b === 1'b1);
                end
            end
        end
        @(posedge clk); #1;
        total++; if (!busy_ok) begin bad++; $display("FAIL gaps_busy got=dropped want=held high"); end
        total++; if (busy_b !== 1'b0 || fd_cnt_b != 1) begin bad++; $display("FAIL gaps_end got=busy%b fd%0d want=busy0 fd1", busy_b, fd_cnt_b); end
        total++;
        if (qb.size() != 4) begin
            bad++; $display("FAIL gaps_count got=%0d want=4", qb.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (qb[j] !== 16'(ex[j])) begin
                    bad++; $display("FAIL gaps_value[%0d] got=%0d want=%0d", j, $signed(qb[j]), ex[j]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int px[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        do_reset();
        for (int i = 0; i < 5; i++) send_pixel(16'(px[i] + 100), 1'b0);
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy_a); end
        rst_n = 1'b0;
        #2;
        total++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin bad++; $display("FAIL mid_reset got=v%b busy%b want=v0 busy0", out_valid_a, busy_a); end
        @(posedge clk); #1;
        qa.delete(); fd_cnt_a = 0;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_pixel(16'(px[i]), 1'b0);
        @(posedge clk); #1;
        total++;
        if (qa.size() != 2 || fd_cnt_a != 1) begin
            bad++; $display("FAIL mid_refill got=outs%0d fd%0d want=outs2 fd1", qa.size(), fd_cnt_a);
        end else if (qa[0] !== 16'd6 || qa[1] !== 16'd8) begin
            bad++; $display("FAIL mid_values got=%0d,%0d want=6,8", qa[0], qa[1]);
        end
    endtask

    task automatic test_back_to_back();
        int px[16] = '{1, 5, -3, 2, 4, 0, -7, -1, 9, 9, -1, -2, -3, -4, 0, -5};
        int ex[4]  = '{5, 2, 9, 0};
        bit busy_ok = 1'b1;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            send_pixel(16'(px[i]), 1'b0);
            busy_ok &= (busy_a === 1'b1);
        end
        @(posedge clk); #1;
        total++; if (!busy_ok) begin bad++; $display("FAIL b2b_busy got=dropped want=held high"); end
        total++; if (fd_cnt_a != 2) begin bad++; $display("FAIL b2b_frame_done got=%0d want=2", fd_cnt_a); end
        total++;
        if (qa.size() != 4) begin
            bad++; $display("FAIL b2b_count got=%0d want=4", qa.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (qa[j] !== 16'(ex[j])) begin
                    bad++; $display("FAIL b2b_value[%0d] got=%0d want=%0d", j, $signed(qa[j]), ex[j]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_gaps_4x4();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_ctrl.md
# maxpool2x2_ctrl

Streaming 2×2/stride-2 max-pooling controller for the CNN pooling stage. Accepts one feature-map pixel per cycle in raster order over a valid/ready stream, buffers the even row, assembles each 2×2 window and sequences it through the four-input signed maximum unit. Emits one pooled pixel per window on a registered valid/ready output. Sits between a convolution/activation stage and the next layer's input buffer.

## Interface

- DATA_WIDTH, 16, pixel width; two's-complement signed.
- IMG_W, 28, input columns per row; even, ≥2.
- IMG_H, 28, input rows per frame; even, ≥2.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  DATA_WIDTH  input pixel, raster order, row 0 column 0 first.
- out_valid  output  1  out_data holds a pooled pixel.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  DATA_WIDTH  pooled pixel, raster order over the (IMG_W/2)×(IMG_H/2) map.
- frame_done  output  1  one-cycle pulse on the handshake of the frame's last pooled pixel.
- busy  output  1  high from the first accepted pixel of a frame until frame_done.

## Operation

- Input handshake: a beat transfers when in_valid && in_ready. in_ready = !out_valid || out_ready. in_ready has no dependence on in_valid.
- Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1. Both advance only on an input beat. col wraps to 0 at IMG_W-1 and increments row. row wraps to 0 at IMG_H-1 with col = IMG_W-1, which ends the frame.
- FSM, 2 states, next state taken on the input beat that completes a row:
  - FILL (row even): store the beat in line_buf[col], where line_buf is IMG_W × DATA_WIDTH. Produces no output. Goes to POOL at col = IMG_W-1.
  - POOL (row odd): on an even col, latch the beat into hold_reg. On an odd col, drive MaxUnit with A = line_buf[col-1], B = line_buf[col], C = hold_reg, D = in_data. Register the result into out_data and set out_valid. Goes to FILL at col = IMG_W-1.
- Max rule: comparison is signed, and on ties the earlier operand wins (A>B>C>D). The result is bit-exact to the combinational max of the four operands. There is no width growth.
- Output register: a single entry. out_valid clears on out_ready unless a new result loads in the same cycle. If a load and an accept coincide, the new value loads and out_valid stays 1.
- busy sets on the first accepted beat with row = 0 and col = 0. It clears in the frame_done cycle. Back-to-back frames are allowed: a new frame's first beat may be accepted in the frame_done cycle, in which case busy stays 1.
- Reset values: FSM = FILL, col = 0, row = 0, out_valid = 0, out_data = 0, frame_done = 0, busy = 0. line_buf and hold_reg are not reset, because they are always written before they are read.
- Reset mid-frame discards the partial frame and pending output. The next beat after reset is treated as pixel (0,0).

## Timing

- Latency: out_valid rises on the clock edge that accepts the window's D pixel, one cycle after that beat is presented.
- Throughput: 1 pixel/cycle sustained when out_ready is held at 1. Output duty cycle is 0 in FILL rows and 50% in POOL rows.
- Backpressure: when out_valid = 1 and out_ready = 0, in_ready = 0 in both states. This stall is conservative and holds even when the pending beat would not produce output.
- frame_done is registered and coincident with the final out_valid && out_ready cycle.

## Structure

- Shared package pool_pkg: the FSM state enum {FILL, POOL} and a localparam function for the counter width, clog2(IMG_W) and clog2(IMG_H).
- One sub-module: instantiate the existing four-input signed max unit, parameterised with DATA_WIDTH. Only the counters, FSM, line buffer, hold register and output register live in this block.
- Elaboration-time assertion: IMG_W and IMG_H must be even.

## Test plan

- IMG_W=4, IMG_H=2, out_ready=1. Rows [1,5,-3,2] and [4,0,-7,-1] -> out_data 5 then 2. Each appears one cycle after its D beat. frame_done pulses with the 2nd output.
- All-negative window [-8,-3] / [-5,-32768] -> out_data -3, confirming signed comparison. Window 0x7FFF with three 0x8000 -> 0x7FFF.
- out_ready held 0 after the first result -> in_ready = 0, out_data stays stable with no beats lost. Releasing out_ready -> stream resumes and output order is preserved.
- IMG_W=IMG_H=4, random in_valid gaps, 16 random pixels -> 4 outputs matching the reference model, busy high throughout, one frame_done.
- rst_n asserted after 5 beats of a frame -> out_valid = 0, busy = 0. A full new frame then pools correctly from (0,0).
- Two back-to-back frames with no idle cycle -> 2 frame_done pulses, busy never drops between frames, all outputs correct.
